tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Shares one free-running prescaler among several independently programmable tick channels. Each channel emits a one-cycle `tick` strobe every `div` base ticks and a 50 %-duty `wave` that toggles on each tick. Channels are configured at run time through a valid/ready port, and reprogramming a running channel is glitch-free. The block sits between the system clock and the timing consumers (display refresh, game step, debounce, buzzer), replacing per-consumer frequency dividers.

## Interface
- `CHANNELS`, 4: number of tick channels, 1..8.
- `BASE_DIV`, 100: system clocks per base tick, ≥2.
- `DIV_W`, 16: width of the per-channel divisor.
- `CW`, derived: `max(1, $clog2(CHANNELS))`, width of the channel index.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config can be accepted for `cfg_chan`.
- `cfg_chan` in CW: target channel.
- `cfg_div` in DIV_W: new divisor, in base ticks.
- `cfg_en` in 1: new enable.
- `base_tick` out 1: one-cycle strobe every `BASE_DIV` clocks.
- `tick` out CHANNELS: per-channel one-cycle strobe.
- `wave` out CHANNELS: per-channel square wave.

## Operation
- **Base counter**
  - `bcnt` counts 0..BASE_DIV-1 and wraps.
  - Internal strobe `s = (bcnt == BASE_DIV-1)`.
  - Free-running; never reset by configuration.
- **Per-channel state:** `en`, `div`, `cnt`, `pending`, `sh_div`, `sh_en`.
- **Active channel:** `en && div != 0`. A channel with `div == 0` behaves as disabled.
- **On `s` for an active channel**
  - If `cnt == div-1`, this is a wrap: `cnt <= 0`, `tick <= 1`, `wave <= ~wave`.
  - Otherwise `cnt <= cnt+1`.
- **Handshake**
  - `cfg_ready = !rst && (cfg_chan >= CHANNELS || !pending[cfg_chan])`.
  - A request is accepted when `cfg_valid && cfg_ready`.
  - An index ≥ CHANNELS is accepted and discarded.
- **Accepted request, channel inactive**
  - Load at that edge: `en <= cfg_en`, `div <= cfg_div`, `cnt <= 0`, `wave <= 0`.
  - No pending state is created.
- **Accepted request, channel active**
  - `sh_* <= cfg_*`, `pending <= 1`.
  - The running period completes with the old `div`.
  - At the next wrap strictly after acceptance: `div`/`en` load from shadow, `pending <= 0`. If the new configuration is inactive, `wave <= 0` on that edge instead of toggling; the wrap's `tick` still fires.
- **Acceptance in the same cycle as a wrap:** the wrap uses the old configuration, and the shadow applies at the following wrap.
- **Simultaneous requests:** different channels are independent; only one request per cycle exists at the port.

## Timing
- **Reset values:** all outputs 0 (`base_tick`, `tick`, `wave`, `cfg_ready`); `bcnt`, `cnt`, `div`, `en`, `pending` all 0.
- **Output registration**
  - All outputs except `cfg_ready` are registered.
  - `base_tick` is high in the cycle after `bcnt == BASE_DIV-1`.
  - After `rst` falls, the first `base_tick` occurs on clock `BASE_DIV`, then every `BASE_DIV` clocks.
- **`tick[i]` alignment:** coincides with `base_tick`, high exactly one cycle. `wave[i]` changes in that same cycle.
- **Enable latency:** enabling an inactive channel with divisor D makes its first tick coincide with the D-th `base_tick` after the accept edge.
- **Steady-state periods:** tick period is D·BASE_DIV clocks; wave period is 2·D·BASE_DIV clocks.
- **`cfg_ready`:** combinational. It drops the cycle after an accept to an active channel and rises the cycle after the applying wrap.
- **Mid-operation reset:** `rst` high at any point clears everything at the next edge. Requests during `rst` are ignored.

## Structure
- **Package `tick_sched_pkg`:**
  - default `CHANNELS`, `BASE_DIV`, `DIV_W`;
  - the channel-state typedef (`en`, `div`, `cnt`, `pending`, `sh_div`, `sh_en`);
  - the `CW` derivation function.
- **Sub-module `tick_channel`**, one instance per channel via generate:
  - inputs: `clk`, `rst`, `s`, accept-for-this-channel, `cfg_div`, `cfg_en`;
  - outputs: `tick`, `wave`, `pending`.
- **Top level:** base counter, `cfg_ready` mux, and index decode.

## Test plan
Parameters: `BASE_DIV=4`, `CHANNELS=3`, `DIV_W=8`.
- **Reset:** hold `rst` 3 cycles.
  - During reset: all outputs 0 and `cfg_ready=0`.
  - After release: `base_tick` on clocks 4, 8, 12…
- **Enable:** enable ch0, div=3, while inactive. `tick[0]` every 12 clocks, first on the 3rd `base_tick` after accept; `wave[0]` has period 24, 12 high / 12 low.
- **Reprogram running ch0 from 3 to 5:**
  - `cfg_ready` with `cfg_chan=0` is low from the next cycle.
  - One more tick 12 clocks after the previous one, then ticks every 20 clocks.
  - `cfg_ready` is high again after the applying wrap.
- **Disable running ch1 (div=2) with `cfg_en=0`:** `tick[1]` fires once more at the wrap, `wave[1]` goes to 0 on that edge, then no further activity. Repeat with `cfg_en=1`, `div=0`: same result.
- **Back-to-back requests:**
  - ch1 div=1, then ch2 div=2 in consecutive cycles, both inactive: both accepted and `cfg_ready` stays 1.
  - `tick[1]` on every `base_tick`; `tick[2]` on every 2nd.
  - `cfg_chan=3`: accepted, no state change.
- **Mid-operation reset:** assert `rst` for 1 cycle while ch0 has `pending=1` and `wave[0]=1`. Next edge: all outputs 0, `pending` cleared, and ch0 stays inactive until reconfigured.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared defaults, channel-state record and width helper for the tick scheduler.
package tick_sched_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int BASE_DIV_DEF = 100;
    localparam int DIV_W_DEF    = 16;

    // Channel state is stored at a fixed wide width; channels zero-extend their
    // DIV_W-bit values into it, so the unused upper bits are constant.
    localparam int MAX_DIV_W = 32;

    typedef struct packed {
        logic                 en;
        logic [MAX_DIV_W-1:0] div;
        logic [MAX_DIV_W-1:0] cnt;
        logic                 pending;
        logic [MAX_DIV_W-1:0] sh_div;
        logic                 sh_en;
    } chan_state_t;

    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divides the shared base strobe and applies shadowed
// reconfiguration only at a period boundary so running outputs never glitch.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             accept,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             tick,
    output logic             wave,
    output logic             pending
);

    chan_state_t st_reg, st_next;
    logic        tick_reg, tick_next;
    logic        wave_reg, wave_next;
    logic        active;
    logic        wrap;
    logic        sh_active;

    assign active    = st_reg.en && (st_reg.div != '0);
    assign sh_active = st_reg.sh_en && (st_reg.sh_div != '0);
    assign wrap      = s && active && (st_reg.cnt == st_reg.div - 1);

    always_comb begin
        st_next   = st_reg;
        tick_next = 1'b0;
        wave_next = wave_reg;

        if (s && active) begin
            if (wrap) begin
                st_next.cnt = '0;
                tick_next   = 1'b1;
                if (st_reg.pending) begin
                    st_next.en      = st_reg.sh_en;
                    st_next.div     = st_reg.sh_div;
                    st_next.pending = 1'b0;
                    // A channel being switched off parks its wave low.
                    wave_next       = sh_active ? ~wave_reg : 1'b0;
                end else begin
                    wave_next = ~wave_reg;
                end
            end else begin
                st_next.cnt = MAX_DIV_W'(DIV_W'(st_reg.cnt + 1));
            end
        end

        // The port never offers a request to a pending channel, so an accept
        // here cannot collide with a shadow apply.
        if (accept) begin
            if (active) begin
                st_next.sh_div  = MAX_DIV_W'(cfg_div);
                st_next.sh_en   = cfg_en;
                st_next.pending = 1'b1;
            end else begin
                st_next.en  = cfg_en;
                st_next.div = MAX_DIV_W'(cfg_div);
                st_next.cnt = '0;
                wave_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_reg   <= '0;
            tick_reg <= 1'b0;
            wave_reg <= 1'b0;
        end else begin
            st_reg   <= st_next;
            tick_reg <= tick_next;
            wave_reg <= wave_next;
        end
    end

    assign tick    = tick_reg;
    assign wave    = wave_reg;
    assign pending = st_reg.pending;

endmodule

// File: rtl/tick_scheduler.sv
// Shared base prescaler feeding a bank of independently programmable tick
// channels behind a single valid/ready configuration port.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int BASE_DIV = BASE_DIV_DEF,
    parameter  int DIV_W    = DIV_W_DEF,
    localparam int CW       = calc_cw(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                cfg_en,
    output logic                base_tick,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave
);

    localparam int BCW = $clog2(BASE_DIV);

    logic [BCW-1:0]      bcnt_reg;
    logic                base_tick_reg;
    logic                s;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] pending;

    assign s = (bcnt_reg == BCW'(BASE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_reg      <= '0;
            base_tick_reg <= 1'b0;
        end else begin
            bcnt_reg      <= s ? '0 : bcnt_reg + BCW'(1);
            base_tick_reg <= s;
        end
    end

    assign base_tick = base_tick_reg;

    // Out-of-range indices hit no channel, so they are always ready and vanish.
    assign cfg_ready = !rst && !(|(hit & pending));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign hit[gi]    = (cfg_chan == CW'(gi));
            assign accept[gi] = cfg_valid && cfg_ready && hit[gi];

            tick_channel #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .s       (s),
                .accept  (accept[gi]),
                .cfg_div (cfg_div),
                .cfg_en  (cfg_en),
                .tick    (tick[gi]),
                .wave    (wave[gi]),
                .pending (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected ticks are queued per channel as
// requests are issued and matched against the strobes as they appear.
module tb_tick_scheduler;

    localparam int NCH = 3;
    localparam int BD  = 4;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       base_tick;
    logic [2:0] tick;
    logic [2:0] wave;

    typedef struct packed {
        logic [31:0] cyc;
        logic        w;
    } exp_t;

    exp_t       q[NCH][$];
    logic [2:0] exp_wave;
    int         cyc;
    int         rst_edge;
    int         total;
    int         bad;

    tick_scheduler #(
        .CHANNELS (NCH),
        .BASE_DIV (BD),
        .DIV_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .base_tick (base_tick),
        .tick      (tick),
        .wave      (wave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int c, input logic w);
        exp_t e;
        e.cyc = c;
        e.w   = w;
        q[ch].push_back(e);
    endtask

    // One clock: count the edge, then check every output at the falling edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (rst) begin
            rst_edge = cyc;
            exp_wave = '0;
            for (int i = 0; i < NCH; i++) q[i].delete();
        end
        @(negedge clk);
        chk("base_tick", base_tick, (cyc > rst_edge) && ((cyc - rst_edge) % BD == 0));
        for (int i = 0; i < NCH; i++) begin
            if (tick[i]) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("tick%0d_unexpected", i), tick[i], 1'b0);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("tick%0d_cycle", i), cyc, e.cyc);
                    exp_wave[i] = e.w;
                end
            end else if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
                e = q[i].pop_front();
                chk($sformatf("tick%0d_missing", i), tick[i], 1'b1);
                exp_wave[i] = e.w;
            end
            chk($sformatf("wave%0d", i), wave[i], exp_wave[i]);
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) cycle();
    endtask

    task automatic chk_ready(input int ch, input logic rdy);
        cfg_chan = 2'(ch);
        #1;
        chk($sformatf("ready_ch%0d", ch), cfg_ready, rdy);
    endtask

    task automatic send(input int ch, input int d, input logic en, input logic rdy);
        cfg_chan  = 2'(ch);
        cfg_div   = 8'(d);
        cfg_en    = en;
        cfg_valid = 1'b1;
        #1;
        chk($sformatf("accept_ready_ch%0d", ch), cfg_ready, rdy);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        cyc       = 0;
        rst_edge  = 0;
        total     = 0;
        bad       = 0;
        exp_wave  = '0;
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd1;
        cfg_en    = 1'b1;

        // Reset held three clocks with a live request that must be ignored.
        repeat (3) begin
            cycle();
            #1;
            chk("ready_in_rst", cfg_ready, 1'b0);
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;

        // Enable inactive ch0 with div=3: accept edge 6, base ticks 7, 11, 15.
        run_to(5);
        push(0, 15, 1'b1);
        push(0, 27, 1'b0);
        push(0, 39, 1'b1);
        send(0, 3, 1'b1, 1'b1);

        // Reprogram running ch0 to 5: last old-period tick at 51, then every 20.
        run_to(43);
        push(0, 51, 1'b0);
        push(0, 71, 1'b1);
        push(0, 91, 1'b0);
        push(0, 111, 1'b1);
        send(0, 5, 1'b1, 1'b1);
        chk_ready(0, 1'b0);
        run_to(50);
        chk_ready(0, 1'b0);
        cycle();
        chk_ready(0, 1'b1);

        // ch1 div=2, then disable with cfg_en=0: final tick at 75 parks wave low.
        run_to(52);
        push(1, 59, 1'b1);
        push(1, 67, 1'b0);
        send(1, 2, 1'b1, 1'b1);
        run_to(68);
        push(1, 75, 1'b0);
        send(1, 2, 1'b0, 1'b1);
        chk_ready(1, 1'b0);

        // Same again, this time switching off with div=0.
        run_to(77);
        push(1, 83, 1'b1);
        push(1, 91, 1'b0);
        send(1, 2, 1'b1, 1'b1);
        run_to(92);
        push(1, 99, 1'b0);
        send(1, 0, 1'b1, 1'b1);

        // Back-to-back loads of inactive ch1/ch2, then a discarded index 3.
        run_to(100);
        push(1, 103, 1'b1);
        push(1, 107, 1'b0);
        push(1, 111, 1'b1);
        push(1, 115, 1'b0);
        push(1, 119, 1'b1);
        send(1, 1, 1'b1, 1'b1);
        push(2, 107, 1'b1);
        push(2, 115, 1'b0);
        send(2, 2, 1'b1, 1'b1);
        send(3, 7, 1'b1, 1'b1);

        // Leave ch0 pending with wave high, then reset mid-operation.
        run_to(115);
        send(0, 2, 1'b1, 1'b1);
        chk_ready(0, 1'b0);
        run_to(120);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_ready(0, 1'b1);

        // Nothing may tick until ch0 is configured again.
        run_to(161);
        push(0, 165, 1'b1);
        push(0, 169, 1'b0);
        send(0, 1, 1'b1, 1'b1);
        run_to(172);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("leftover_ticks%0d", i), q[i].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
